// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned W x W multiplier with a runtime exact/approximate mode, valid/ready
// flow control and a saturating count of approximate results delivered.
module approx_mult_pipe #(
    parameter int W      = 8,
    parameter int L      = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*W-1:0]   z_o,
    output logic             out_mode_o,
    output logic [CNT_W-1:0] approx_cnt_o
);

    localparam int PW       = 2 * W;
    localparam int NumPairs = (L + 1) / 2;

    function automatic logic pp_bit(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input int i, input int c);
        int j;
        j      = c - i;
        pp_bit = 1'b0;
        if (j >= 0 && j < W) begin
            pp_bit = x[i] & y[j];
        end
    endfunction

    logic [PW-1:0] exact_prod;
    logic [PW-1:0] hi_prod;
    logic [PW-1:0] lo_approx;
    logic [PW-1:0] prod;
    logic          col_or;
    logic          pa;
    logic          pb;

    always_comb begin
        exact_prod = PW'(x_i) * PW'(y_i);
        hi_prod    = (PW'(x_i[W-1:L]) * PW'(y_i)) << L;

        // Column W-1 collapses to a single OR, promoted one weight up.
        col_or = 1'b0;
        for (int i = 0; i < L; i++) begin
            col_or = col_or | (x_i[i] & y_i[W-1-i]);
        end
        lo_approx = PW'(col_or) << W;

        // Upper columns: each row pair compresses to OR at weight c plus AND at c+1.
        pa = 1'b0;
        pb = 1'b0;
        for (int p = 0; p < NumPairs; p++) begin
            for (int c = W; c < W + L - 1; c++) begin
                pa        = pp_bit(x_i, y_i, 2 * p, c);
                pb        = (2 * p + 1 < L) ? pp_bit(x_i, y_i, 2 * p + 1, c) : 1'b0;
                lo_approx = lo_approx + (PW'(pa | pb) << c) + (PW'(pa & pb) << (c + 1));
            end
        end

        prod = mode_i ? (hi_prod + lo_approx) : exact_prod;
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] mode_q;
    logic [STAGES-1:0] mode_d;
    logic [PW-1:0]     z_q [STAGES];
    logic [PW-1:0]     z_d [STAGES];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              en;
    logic              out_fire;

    assign en       = out_ready_i | ~vld_q[STAGES-1];
    assign out_fire = vld_q[STAGES-1] & out_ready_i;

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        z_d    = z_q;
        if (en) begin
            // in_ready equals en, so in_valid here is exactly the input transfer.
            vld_d[0]  = in_valid_i;
            mode_d[0] = mode_i;
            z_d[0]    = prod;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                mode_d[s] = mode_q[s-1];
                z_d[s]    = z_q[s-1];
            end
        end

        cnt_d = cnt_q;
        if (out_fire && mode_q[STAGES-1] && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            mode_q <= '0;
            cnt_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                z_q[s] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    assign in_ready_o   = en;
    assign out_valid_o  = vld_q[STAGES-1];
    assign z_o          = z_q[STAGES-1];
    assign out_mode_o   = mode_q[STAGES-1];
    assign approx_cnt_o = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed cases plus randomized traffic
// scored against a word-level reference model and an in-order expectation queue.
module tb_approx_mult_pipe;

    localparam int W      = 8;
    localparam int L      = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;
    localparam int PW     = 2 * W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             mode = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     x = '0;
    logic [W-1:0]     y = '0;
    logic             in_ready, out_valid, out_mode;
    logic [PW-1:0]    z;
    logic [CNT_W-1:0] approx_cnt;
    logic             in_ready2, out_valid2, out_mode2;
    logic [PW-1:0]    z2;
    logic [1:0]       approx_cnt2;

    always #5 clk = ~clk;

    approx_mult_pipe #(.W(W), .L(L), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .x_i          (x),
        .y_i          (y),
        .mode_i       (mode),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .z_o          (z),
        .out_mode_o   (out_mode),
        .approx_cnt_o (approx_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    approx_mult_pipe #(.W(W), .L(L), .STAGES(STAGES), .CNT_W(2)) u_dut_cnt2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready2),
        .x_i          (x),
        .y_i          (y),
        .mode_i       (mode),
        .out_valid_o  (out_valid2),
        .out_ready_i  (out_ready),
        .z_o          (z2),
        .out_mode_o   (out_mode2),
        .approx_cnt_o (approx_cnt2)
    );

    typedef struct {
        logic [PW-1:0] z;
        logic          m;
        int            acc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_out = 0;
    int unsigned exp_cnt = 0;
    int unsigned exp_cnt2 = 0;
    bit          strict = 1'b0;
    bit          prev_stall = 1'b0;
    logic [W-1:0] edge_vals [6] = '{8'h00, 8'hFF, 8'h80, 8'h0F, 8'hF0, 8'h01};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Approximate product: exact upper rows, then the low rows' bits at weight >= 2^W
    // counted once each, plus the pairwise overlap once more, plus the column W-1 OR bit.
    function automatic int unsigned ref_prod(input int unsigned xv, input int unsigned yv,
                                             input bit m);
        int unsigned acc, hi_mask;
        int unsigned row [L];
        bit          col_or;
        if (!m) return xv * yv;
        hi_mask = ~((32'd1 << W) - 1);
        acc     = ((xv >> L) * yv) << L;
        col_or  = 1'b0;
        for (int i = 0; i < L; i++) begin
            row[i] = (((xv >> i) & 1) != 0) ? (yv << i) : 0;
            acc += row[i] & hi_mask;
            if (((row[i] >> (W - 1)) & 1) != 0) col_or = 1'b1;
        end
        for (int i = 0; i + 1 < L; i += 2) acc += row[i] & row[i+1] & hi_mask;
        if (col_or) acc += (32'd1 << W);
        return acc & ((32'd1 << PW) - 1);
    endfunction

    // Entered just after a clock edge; checks outputs, scores the handshakes, waits one cycle.
    task automatic drive_cycle(input bit iv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                               input bit mv, input bit ordy, input int exp_z, output bit acc);
        exp_t e;
        in_valid  = iv;
        x         = xv;
        y         = yv;
        mode      = mv;
        out_ready = ordy;
        #1;
        check_eq("in_ready", in_ready, ordy | !out_valid);
        if (prev_stall) check_eq("stall_out_valid", out_valid, 1);
        if (strict && q.size() > 0) check_eq("latency", out_valid, (cyc - q[0].acc) == STAGES);
        if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out_valid", out_valid, 0);
            end else begin
                check_eq("z", z, q[0].z);
                check_eq("out_mode", out_mode, q[0].m);
            end
        end
        check_eq("approx_cnt", approx_cnt, exp_cnt);
        check_eq("approx_cnt_w2", approx_cnt2, exp_cnt2);
        if (out_valid && ordy && q.size() > 0) begin
            if (q[0].m) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            void'(q.pop_front());
            n_out++;
        end
        acc = iv && in_ready;
        if (acc) begin
            e.z   = (exp_z >= 0) ? PW'(exp_z) : PW'(ref_prod(int'(xv), int'(yv), mv));
            e.m   = mv;
            e.acc = cyc;
            q.push_back(e);
        end
        prev_stall = out_valid && !ordy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input bit iv);
        rst       = 1'b1;
        in_valid  = iv;
        x         = W'($urandom);
        y         = W'($urandom);
        mode      = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        q.delete();
        exp_cnt    = 0;
        exp_cnt2   = 0;
        prev_stall = 1'b0;
        cyc++;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_z", z, 0);
        check_eq("rst_out_mode", out_mode, 0);
        check_eq("rst_approx_cnt", approx_cnt, 0);
        check_eq("rst_approx_cnt_w2", approx_cnt2, 0);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, -1, a);
    endtask

    task automatic drain(input string tag);
        bit a;
        int k;
        k = 0;
        while (q.size() > 0 && k < 50) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, -1, a);
            k++;
        end
        check_eq(tag, q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit a;
        int i, k, n, out0;
        do_reset(1'b0);
        do_reset(1'b1);

        // Directed products with out_ready held high, latency checked exactly.
        strict = 1'b1;
        drive_cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 'hFE01, a);
        idle(3);
        drive_cycle(1'b1, 8'h0F, 8'hFF, 1'b1, 1'b1, 'h0F00, a);
        idle(3);
        check_eq("T2_approx_cnt", approx_cnt, 1);
        drive_cycle(1'b1, 8'hF0, 8'hFF, 1'b1, 1'b1, 'hEF10, a);
        idle(3);
        check_eq("T3_approx_cnt", approx_cnt, 2);

        // Back-to-back stream with a three-cycle downstream stall.
        strict = 1'b0;
        out0   = n_out;
        i      = 0;
        k      = 0;
        while (i < 10 && k < 40) begin
            drive_cycle(1'b1, W'($urandom), W'($urandom), i[0], !(k >= 4 && k < 7), -1, a);
            if (a) i++;
            k++;
        end
        check_eq("T4_accepted", i, 10);
        drain("T4_drained");
        check_eq("T4_delivered", n_out - out0, 10);

        // Reset with two results in flight.
        drive_cycle(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0, -1, a);
        drive_cycle(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0, -1, a);
        do_reset(1'b1);
        idle(4);
        strict = 1'b1;
        drive_cycle(1'b1, 8'hA7, 8'h5B, 1'b1, 1'b1, -1, a);
        idle(3);
        check_eq("T5_delivered", q.size(), 0);

        // Random traffic, 10k accepted pairs per mode.
        strict = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n = 0;
            k = 0;
            while (n < 10000 && k < 40000) begin
                logic [W-1:0] xv, yv;
                xv = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
                yv = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
                drive_cycle($urandom_range(0, 9) < 9, xv, yv, m[0], $urandom_range(0, 9) < 8,
                            -1, a);
                if (a) n++;
                k++;
            end
            check_eq("T6_accepted", n, 10000);
            drain("T6_drained");
        end
        check_eq("T6_approx_cnt_w2_sat", approx_cnt2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
